// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller.
// State encoding matches the cur_state output field.
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_GREEN     = 2'b00,
      ST_YELLOW    = 2'b01,
      ST_ALLRED    = 2'b10,
      ST_PRE_GREEN = 2'b11
   } state_e;

   localparam int DEF_T_GREEN  = 30;
   localparam int DEF_T_YELLOW = 5;
   localparam int DEF_T_BUF    = 5;

   localparam int HEAD_LEFT      = 0;
   localparam int HEAD_STRAIGHT  = 1;
   localparam int HEAD_RIGHT     = 2;
   localparam int HEADS_PER_ROAD = 3;

   function automatic int head_idx(input int road, input int dir);
      return HEADS_PER_ROAD * road + dir;
   endfunction

endpackage

// File: rtl/traffic_phase_ctrl_next_phase.sv
// Cyclic next-phase search: plain increment, or the first
// pending phase after cur_phase when skipping is enabled.
module traffic_next_phase
   import traffic_pkg::*;
#(
   parameter int NUM_PHASES = 4,
   localparam int PW = $clog2(NUM_PHASES)
) (
   input  logic [NUM_PHASES-1:0] pend,
   input  logic [PW-1:0]         cur_phase,
   input  logic                  skip_en,
   output logic [PW-1:0]         next_phase,
   output logic                  found
);

   logic [PW-1:0] inc;
   logic [PW-1:0] idx;

   always_comb begin
      inc = (cur_phase == PW'(NUM_PHASES - 1)) ?
            '0 : cur_phase + 1'b1;
      idx = '0;
      next_phase = inc;
      found = 1'b1;
      if (skip_en) begin
         found = 1'b0;
         // Walk farthest-first so the nearest hit wins.
         for (int i = NUM_PHASES; i >= 1; i--) begin
            idx = PW'((int'(cur_phase) + i) % NUM_PHASES);
            if (pend[idx]) begin
               found = 1'b1;
               next_phase = idx;
            end
         end
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer with demand skipping and
// emergency preemption; lamps decode from registered state only.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int NUM_PHASES = 4,
   parameter int NUM_SIG    = 12,
   parameter int CNT_W      = 8,
   parameter int T_GREEN    = DEF_T_GREEN,
   parameter int T_YELLOW   = DEF_T_YELLOW,
   parameter int T_BUF      = DEF_T_BUF,
   parameter logic [NUM_PHASES*NUM_SIG-1:0] PHASE_MASK =
      {12'h900, 12'h618, 12'h024, 12'h0C3},
   localparam int PW = $clog2(NUM_PHASES)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  tick,
   input  logic [NUM_PHASES-1:0] req,
   input  logic                  skip_en,
   input  logic                  preempt,
   input  logic [PW-1:0]         preempt_phase,
   output logic [NUM_SIG-1:0]    red,
   output logic [NUM_SIG-1:0]    yellow,
   output logic [NUM_SIG-1:0]    green,
   output logic [PW-1:0]         cur_phase,
   output logic [1:0]            cur_state,
   output logic                  preempt_active,
   output logic                  cycle_done
);

   state_e                state_q, state_d;
   logic [PW-1:0]         phase_q, phase_d;
   logic [PW-1:0]         pre_ph_q, pre_ph_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_end;
   logic [NUM_PHASES-1:0] pend_q, pend_d, clr;
   logic                  pre_act_q, pre_act_d;
   logic                  done_q, done_d;
   logic                  accept, pre_hit, expire, enter;
   logic [PW-1:0]         pre_tgt, nxt_ph;
   logic                  found;
   logic [NUM_SIG-1:0]    masks [NUM_PHASES];
   logic [NUM_SIG-1:0]    mask;

   traffic_next_phase #(.NUM_PHASES(NUM_PHASES)) u_next (
      .pend       (pend_q),
      .cur_phase  (phase_q),
      .skip_en    (skip_en),
      .next_phase (nxt_ph),
      .found      (found)
   );

   assign accept  = preempt &&
                    (32'(preempt_phase) < 32'(NUM_PHASES));
   assign pre_hit = pre_act_q | accept;
   assign pre_tgt = pre_act_q ? pre_ph_q : preempt_phase;

   always_comb begin
      unique case (state_q)
         ST_GREEN:  cnt_end = CNT_W'(T_GREEN - 1);
         ST_YELLOW: cnt_end = CNT_W'(T_YELLOW - 1);
         default:   cnt_end = CNT_W'(T_BUF - 1);
      endcase
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      pre_act_d = pre_act_q;
      pre_ph_d  = pre_ph_q;
      done_d    = 1'b0;
      enter     = 1'b0;
      expire    = tick && (cnt_q == cnt_end);
      if (tick) cnt_d = cnt_q + 1'b1;
      // Target is captured once so later changes cannot redirect it.
      if (accept && !pre_act_q && state_q != ST_PRE_GREEN) begin
         pre_act_d = 1'b1;
         pre_ph_d  = preempt_phase;
      end
      unique case (state_q)
         ST_GREEN: begin
            if (accept) begin
               cnt_d = '0;
               if (preempt_phase == phase_q) begin
                  state_d = ST_PRE_GREEN;
                  enter   = 1'b1;
               end else begin
                  state_d = ST_YELLOW;
               end
            end else if (expire) begin
               state_d = ST_YELLOW;
               cnt_d   = '0;
            end
         end
         ST_YELLOW: begin
            if (expire) begin
               state_d = ST_ALLRED;
               cnt_d   = '0;
            end
         end
         ST_ALLRED: begin
            if (expire) begin
               if (pre_hit) begin
                  state_d   = ST_PRE_GREEN;
                  phase_d   = pre_tgt;
                  pre_act_d = 1'b1;
                  cnt_d     = '0;
                  enter     = 1'b1;
               end else if (found) begin
                  state_d = ST_GREEN;
                  phase_d = nxt_ph;
                  done_d  = (nxt_ph <= phase_q);
                  cnt_d   = '0;
                  enter   = 1'b1;
               end else begin
                  cnt_d = cnt_q;
               end
            end
         end
         ST_PRE_GREEN: begin
            cnt_d = cnt_q;
            if (!preempt) begin
               state_d   = ST_YELLOW;
               pre_act_d = 1'b0;
               cnt_d     = '0;
            end
         end
      endcase
      clr = '0;
      if (enter) clr[phase_d] = 1'b1;
      pend_d = (pend_q | req) & ~clr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_ALLRED;
         phase_q   <= PW'(NUM_PHASES - 1);
         pre_ph_q  <= '0;
         cnt_q     <= '0;
         pend_q    <= '0;
         pre_act_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         pre_ph_q  <= pre_ph_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pre_act_q <= pre_act_d;
         done_q    <= done_d;
      end
   end

   for (genvar g = 0; g < NUM_PHASES; g++) begin : g_mask
      assign masks[g] = PHASE_MASK[g*NUM_SIG +: NUM_SIG];
   end

   assign mask   = masks[phase_q];
   assign green  = (state_q == ST_GREEN ||
                    state_q == ST_PRE_GREEN) ? mask : '0;
   assign yellow = (state_q == ST_YELLOW) ? mask : '0;
   assign red    = ~(green | yellow);

   assign cur_phase      = phase_q;
   assign cur_state      = state_q;
   assign preempt_active = pre_act_q;
   assign cycle_done     = done_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: timeline model, directed
// preemption/reset scenarios and randomized invariant runs.
module tb_traffic_phase_ctrl;

   localparam int NP = 4;
   localparam int TG = 30;
   localparam int TY = 5;
   localparam int TB = 5;
   localparam logic [11:0] MASKS [4] =
      '{12'h0C3, 12'h024, 12'h618, 12'h900};

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        tick = 1'b0;
   logic [3:0]  req = '0;
   logic        skip_en = 1'b0;
   logic        preempt = 1'b0;
   logic [1:0]  preempt_phase = '0;
   logic [11:0] red, yellow, green;
   logic [1:0]  cur_phase, cur_state;
   logic        preempt_active, cycle_done;

   logic [11:0] red3, yellow3, green3;
   logic [1:0]  cur_phase3, cur_state3;
   logic        preempt_active3, cycle_done3;

   int n_tests = 0;
   int n_fail = 0;

   // Timeline model: stage 0 green, 1 yellow, 2 all-red.
   int       m_ph, m_stage, m_left;
   bit [3:0] m_pend;
   bit       m_done;
   bit       mdl_on = 0;
   bit       inv_on = 0;
   bit       c3_on = 0;
   int       k3 = 0;
   logic [1:0] prev_st = 2'd2;
   logic [3:0] seen = '0;

   traffic_phase_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .tick           (tick),
      .req            (req),
      .skip_en        (skip_en),
      .preempt        (preempt),
      .preempt_phase  (preempt_phase),
      .red            (red),
      .yellow         (yellow),
      .green          (green),
      .cur_phase      (cur_phase),
      .cur_state      (cur_state),
      .preempt_active (preempt_active),
      .cycle_done     (cycle_done)
   );

   traffic_phase_ctrl #(
      .NUM_PHASES (3),
      .PHASE_MASK ({12'h618, 12'h024, 12'h0C3})
   ) dut3 (
      .clk            (clk),
      .reset_n        (reset_n),
      .tick           (tick),
      .req            (req[2:0]),
      .skip_en        (skip_en),
      .preempt        (1'b1),
      .preempt_phase  (2'd3),
      .red            (red3),
      .yellow         (yellow3),
      .green          (green3),
      .cur_phase      (cur_phase3),
      .cur_state      (cur_state3),
      .preempt_active (preempt_active3),
      .cycle_done     (cycle_done3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, want);
      end
   endtask

   task automatic model_reset();
      m_ph = NP - 1;
      m_stage = 2;
      m_left = TB;
      m_pend = '0;
      m_done = 0;
   endtask

   task automatic model_step(input bit tk, input bit [3:0] rq,
                             input bit sk);
      int nph;
      bit ent;
      nph = -1;
      ent = 0;
      m_done = 0;
      if (tk) begin
         if (m_left > 1) m_left--;
         else if (m_stage == 0) begin
            m_stage = 1;
            m_left = TY;
         end else if (m_stage == 1) begin
            m_stage = 2;
            m_left = TB;
         end else begin
            if (!sk) nph = (m_ph + 1) % NP;
            else
               for (int i = 1; i <= NP; i++)
                  if (nph < 0 && m_pend[(m_ph + i) % NP])
                     nph = (m_ph + i) % NP;
            if (nph >= 0) begin
               m_done = (nph <= m_ph);
               m_ph = nph;
               m_stage = 0;
               m_left = TG;
               ent = 1;
            end
         end
      end
      m_pend = m_pend | rq;
      if (ent) m_pend[m_ph] = 1'b0;
   endtask

   task automatic model_check();
      logic [11:0] g, y;
      g = (m_stage == 0) ? MASKS[m_ph] : 12'h0;
      y = (m_stage == 1) ? MASKS[m_ph] : 12'h0;
      chk("m_phase", cur_phase, m_ph);
      chk("m_state", cur_state, m_stage);
      chk("m_green", green, g);
      chk("m_yellow", yellow, y);
      chk("m_red", red, ~(g | y) & 12'hFFF);
      chk("m_done", cycle_done, m_done);
   endtask

   // Closed-form schedule of the 3-phase instance, preempt ignored.
   task automatic c3_check();
      int j, ph, pos, st;
      bit dn;
      k3++;
      if (k3 < TB) begin
         ph = 2;
         st = 2;
         dn = 0;
      end else begin
         j = k3 - TB;
         ph = (j / (TG + TY + TB)) % 3;
         pos = j % (TG + TY + TB);
         st = (pos < TG) ? 0 : (pos < TG + TY) ? 1 : 2;
         dn = (pos == 0) && (ph == 0);
      end
      chk("p3_phase", cur_phase3, ph);
      chk("p3_state", cur_state3, st);
      chk("p3_active", preempt_active3, 0);
      chk("p3_done", cycle_done3, dn);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (mdl_on) model_step(tick, req, skip_en);
      #1;
      if (mdl_on) model_check();
      if (c3_on) c3_check();
      if (green != 0) seen[cur_phase] = 1'b1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick = 1'b0;
      req = '0;
      preempt = 1'b0;
      preempt_phase = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      k3 = 0;
      seen = '0;
      reset_n = 1'b1;
   endtask

   task automatic wait_state(input logic [1:0] s, input int lim,
                             input string tag);
      for (int i = 0; i < lim && cur_state !== s; i++) cyc();
      chk(tag, cur_state, s);
   endtask

   always @(negedge clk) begin
      if (!reset_n) prev_st = 2'd2;
      else if (inv_on) begin
         chk("onehot",
             ((red ^ yellow ^ green) == 12'hFFF) &&
             (((red & yellow) | (red & green) |
               (yellow & green)) == 12'h0), 1);
         chk("onehot3",
             ((red3 ^ yellow3 ^ green3) == 12'hFFF) &&
             (((red3 & yellow3) | (red3 & green3) |
               (yellow3 & green3)) == 12'h0), 1);
         if (prev_st == 2'd1)
            chk("no_g_after_y", cur_state inside {2'd0, 2'd3}, 0);
         prev_st = cur_state;
      end
   end

   initial begin
      // Reset values while reset_n is held low.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_red", red, 12'hFFF);
      chk("rst_green", green, 0);
      chk("rst_yellow", yellow, 0);
      chk("rst_state", cur_state, 2);
      chk("rst_phase", cur_phase, 3);
      chk("rst_active", preempt_active, 0);
      chk("rst_done", cycle_done, 0);

      // Fixed cycle, tick every cycle; 3-phase DUT ignores preempt.
      inv_on = 1;
      skip_en = 1'b0;
      do_reset();
      tick = 1'b1;
      mdl_on = 1;
      c3_on = 1;
      repeat (5 + 2 * 4 * (TG + TY + TB)) cyc();
      c3_on = 0;

      // Randomized tick/req/skip against the model.
      for (int i = 0; i < 3000; i++) begin
         tick = ($urandom_range(0, 3) != 0);
         req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         if (i % 300 == 0) skip_en = 1'($urandom);
         cyc();
      end

      // Demand skipping: only phase 2 is ever requested.
      skip_en = 1'b1;
      do_reset();
      tick = 1'b1;
      req = 4'b0100;
      cyc();
      req = '0;
      repeat (200) cyc();
      chk("skip_seen", seen, 4'b0100);
      chk("skip_rest", cur_state, 2);
      mdl_on = 0;

      // Preemption into phase 3 from phase-0 green at cnt 10.
      skip_en = 1'b0;
      do_reset();
      tick = 1'b1;
      wait_state(2'd0, 20, "pre_wait_g");
      chk("pre_g_phase", cur_phase, 0);
      repeat (10) cyc();
      preempt = 1'b1;
      preempt_phase = 2'd3;
      cyc();
      chk("pre_y_state", cur_state, 1);
      chk("pre_y_lamp", yellow, 12'h0C3);
      chk("pre_active", preempt_active, 1);
      repeat (4) cyc();
      chk("pre_y_end", cur_state, 1);
      cyc();
      chk("pre_ar", cur_state, 2);
      repeat (4) cyc();
      chk("pre_ar_end", cur_state, 2);
      cyc();
      chk("pre_pg_state", cur_state, 3);
      chk("pre_pg_phase", cur_phase, 3);
      preempt_phase = 2'd1;
      for (int i = 0; i < 100; i++) begin
         cyc();
         chk("pre_hold_st", cur_state, 3);
         chk("pre_hold_g", green, 12'h900);
      end
      preempt = 1'b0;
      cyc();
      chk("exit_y_state", cur_state, 1);
      chk("exit_y_lamp", yellow, 12'h900);
      chk("exit_inactive", preempt_active, 0);
      repeat (5) cyc();
      chk("exit_ar", cur_state, 2);
      repeat (4) cyc();
      chk("exit_ar_end", cur_state, 2);
      cyc();
      chk("exit_g_state", cur_state, 0);
      chk("exit_g_lamp", green, 12'h0C3);
      chk("exit_done", cycle_done, 1);

      // Preempting the phase already green goes straight in.
      preempt = 1'b1;
      preempt_phase = 2'd0;
      cyc();
      chk("own_pg_state", cur_state, 3);
      chk("own_pg_lamp", green, 12'h0C3);
      preempt = 1'b0;
      cyc();
      chk("own_exit_y", cur_state, 1);

      // Asynchronous reset in yellow.
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_red", red, 12'hFFF);
      chk("arst_state", cur_state, 2);
      chk("arst_yellow", yellow, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (4) cyc();
      chk("arst_ar", cur_state, 2);
      cyc();
      chk("arst_g_state", cur_state, 0);
      chk("arst_g_phase", cur_phase, 0);

      // Random run including preemption; invariants only.
      for (int i = 0; i < 3000; i++) begin
         tick = ($urandom_range(0, 3) != 0);
         req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 39) == 0) preempt = ~preempt;
         if ($urandom_range(0, 19) == 0)
            preempt_phase = 2'($urandom_range(0, 3));
         if (i % 250 == 0) skip_en = 1'($urandom);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
